// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding architectural HI/LO.
// Shift-add multiply and restoring divide, one step per cycle, sign fix-up in a final cycle.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start_E,
   input  logic [1:0]       MDUOp_E,
   input  logic [WIDTH-1:0] SrcA_E,
   input  logic [WIDTH-1:0] SrcB_E,
   input  logic             WriteHi_E,
   input  logic             WriteLo_E,
   input  logic             HiLoSel_E,
   output logic [WIDTH-1:0] HiLo_E,
   input  logic             MDUUse_D,
   output logic             MDUBusy,
   output logic             MDUStall_D,
   output logic             Done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   hi, lo, opnd;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               is_div, div_zero, neg_res, neg_rem;

   logic               signed_op, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      signed_op = ~MDUOp_E[0];
      b_zero    = (SrcB_E == '0);
      a_mag     = (signed_op && SrcA_E[WIDTH-1]) ? -SrcA_E : SrcA_E;
      b_mag     = (signed_op && SrcB_E[WIDTH-1]) ? -SrcB_E : SrcB_E;
      // Multiply: acc = {partial product, remaining multiplier bits}
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      // Divide: acc = {partial remainder, dividend bits shifting into quotient}
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ok    = ~div_diff[WIDTH];
      prod_fix  = neg_res ? -acc : acc;
      quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (Start_E) begin
               if (!MDUOp_E[1])  state_nxt = S_MUL;
               else if (b_zero)  state_nxt = S_FIX;
               else              state_nxt = S_DIV;
            end
         end
         S_MUL, S_DIV: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:        state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start_E) begin
                  cnt      <= CW'(WIDTH - 1);
                  is_div   <= MDUOp_E[1];
                  div_zero <= MDUOp_E[1] && b_zero;
                  neg_res  <= signed_op && (SrcA_E[WIDTH-1] ^ SrcB_E[WIDTH-1]);
                  neg_rem  <= signed_op && SrcA_E[WIDTH-1];
                  if (!MDUOp_E[1]) begin
                     acc  <= {{WIDTH{1'b0}}, b_mag};
                     opnd <= a_mag;
                  end else begin
                     // divide-by-zero keeps the raw dividend for HI
                     acc  <= {{WIDTH{1'b0}}, b_zero ? SrcA_E : a_mag};
                     opnd <= b_mag;
                  end
               end else begin
                  if (WriteHi_E) hi <= SrcA_E;
                  if (WriteLo_E) lo <= SrcA_E;
               end
            end
            S_MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            S_DIV: begin
               acc <= {div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                       acc[WIDTH-2:0], div_ok};
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               if (div_zero) begin
                  lo <= '1;
                  hi <= acc[WIDTH-1:0];
               end else if (is_div) begin
                  lo <= quot_fix;
                  hi <= rem_fix;
               end else begin
                  lo <= prod_fix[WIDTH-1:0];
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

   assign HiLo_E     = HiLoSel_E ? hi : lo;
   assign MDUBusy    = (state != S_IDLE);
   assign MDUStall_D = MDUBusy & MDUUse_D;
   assign Done       = (state == S_FIX);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic 64-bit reference.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Start_E;
   logic [1:0]  MDUOp_E;
   logic [31:0] SrcA_E, SrcB_E;
   logic        WriteHi_E, WriteLo_E, HiLoSel_E;
   logic [31:0] HiLo_E;
   logic        MDUUse_D, MDUBusy, MDUStall_D, Done;

   int n_checks = 0;
   int n_errors = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .Start_E(Start_E), .MDUOp_E(MDUOp_E),
      .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .WriteHi_E(WriteHi_E), .WriteLo_E(WriteLo_E),
      .HiLoSel_E(HiLoSel_E), .HiLo_E(HiLo_E), .MDUUse_D(MDUUse_D),
      .MDUBusy(MDUBusy), .MDUStall_D(MDUStall_D), .Done(Done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Returns {HI, LO} as the architecture defines them.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, uq, ur;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
      case (op)
         2'd0: return sa * sb;
         2'd1: return ua * ub;
         2'd2: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
      endcase
   endfunction

   task automatic read_hilo(output logic [31:0] hi_v, output logic [31:0] lo_v);
      HiLoSel_E = 1'b0; #1; lo_v = HiLo_E;
      HiLoSel_E = 1'b1; #1; hi_v = HiLo_E;
      HiLoSel_E = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      logic [63:0] exp;
      logic [31:0] hi_v, lo_v;
      int          cycles, done_cnt, exp_busy;
      bit          last_done;
      exp      = ref_result(op, a, b);
      exp_busy = (op[1] && b == 32'd0) ? 1 : 33;
      @(negedge clk);
      Start_E = 1'b1; MDUOp_E = op; SrcA_E = a; SrcB_E = b; MDUUse_D = 1'b1;
      @(negedge clk);
      Start_E = 1'b0;
      cycles = 0; done_cnt = 0; last_done = 1'b0;
      while (MDUBusy && cycles < 100) begin
         cycles++;
         chk("stall_busy", {63'd0, MDUStall_D}, 64'd1);
         if (Done) done_cnt++;
         last_done = Done;
         if (inject && cycles == 10) begin
            Start_E = 1'b1; WriteHi_E = 1'b1; WriteLo_E = 1'b1;
            MDUOp_E = ~op; SrcA_E = $urandom; SrcB_E = $urandom;
         end else begin
            Start_E = 1'b0; WriteHi_E = 1'b0; WriteLo_E = 1'b0;
         end
         @(negedge clk);
      end
      chk("busy_cycles", 64'(cycles), 64'(exp_busy));
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("done_last", {63'd0, last_done}, 64'd1);
      chk("stall_idle", {63'd0, MDUStall_D}, 64'd0);
      read_hilo(hi_v, lo_v);
      chk("lo", {32'd0, lo_v}, {32'd0, exp[31:0]});
      chk("hi", {32'd0, hi_v}, {32'd0, exp[63:32]});
      MDUUse_D = 1'b0;
   endtask

   initial begin
      logic [31:0] hi_v, lo_v, ra, rb;
      logic [1:0]  rop;
      int          cycles, done_cnt;

      rst_n = 1'b0; Start_E = 1'b0; MDUOp_E = 2'd0; SrcA_E = '0; SrcB_E = '0;
      WriteHi_E = 1'b0; WriteLo_E = 1'b0; HiLoSel_E = 1'b0; MDUUse_D = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_busy", {63'd0, MDUBusy}, 64'd0);
      chk("rst_done", {63'd0, Done}, 64'd0);
      read_hilo(hi_v, lo_v);
      chk("rst_lo", {32'd0, lo_v}, 64'd0);
      chk("rst_hi", {32'd0, hi_v}, 64'd0);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 1'b0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0);
      run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(2'd0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

      // reset in the middle of a DIVU
      @(negedge clk);
      Start_E = 1'b1; MDUOp_E = 2'd3; SrcA_E = 32'd1000000; SrcB_E = 32'd3;
      @(negedge clk);
      Start_E = 1'b0;
      cycles = 1;
      while (MDUBusy && cycles < 10) begin
         cycles++;
         @(negedge clk);
      end
      chk("rst_mid_reach", 64'(cycles), 64'd10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid_busy", {63'd0, MDUBusy}, 64'd0);
      read_hilo(hi_v, lo_v);
      chk("rst_mid_lo", {32'd0, lo_v}, 64'd0);
      chk("rst_mid_hi", {32'd0, hi_v}, 64'd0);
      done_cnt = 0;
      repeat (40) begin
         if (Done) done_cnt++;
         @(negedge clk);
      end
      chk("rst_mid_nodone", 64'(done_cnt), 64'd0);
      read_hilo(hi_v, lo_v);
      chk("rst_mid_lo_late", {32'd0, lo_v}, 64'd0);

      // MTLO / MTHI / both
      WriteLo_E = 1'b1; SrcA_E = 32'hCAFE_BABE;
      @(negedge clk);
      WriteLo_E = 1'b0;
      read_hilo(hi_v, lo_v);
      chk("mtlo_lo", {32'd0, lo_v}, 64'h0000_0000_CAFE_BABE);
      chk("mtlo_hi", {32'd0, hi_v}, 64'd0);
      WriteHi_E = 1'b1; SrcA_E = 32'h1357_9BDF;
      @(negedge clk);
      WriteHi_E = 1'b0;
      read_hilo(hi_v, lo_v);
      chk("mthi_hi", {32'd0, hi_v}, 64'h0000_0000_1357_9BDF);
      chk("mthi_lo", {32'd0, lo_v}, 64'h0000_0000_CAFE_BABE);
      WriteHi_E = 1'b1; WriteLo_E = 1'b1; SrcA_E = 32'h0BAD_F00D;
      @(negedge clk);
      WriteHi_E = 1'b0; WriteLo_E = 1'b0;
      read_hilo(hi_v, lo_v);
      chk("mtboth_hi", {32'd0, hi_v}, 64'h0000_0000_0BAD_F00D);
      chk("mtboth_lo", {32'd0, lo_v}, 64'h0000_0000_0BAD_F00D);

      // randomized ops
      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         run_op(rop, ra, rb, (i % 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the Execute stage of the MIPS pipeline. Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and services MTHI, MTLO, MFHI and MFLO.
- It is the requesting side of the stall interface. It raises a busy/stall request that the hazard unit turns into Stall_F, Stall_D and Flush_E.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- Start_E  input  1  MDU arithmetic op valid in Execute.
- MDUOp_E  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA_E  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- SrcB_E  input  WIDTH  rt operand (divisor / multiplier).
- WriteHi_E  input  1  MTHI.
- WriteLo_E  input  1  MTLO.
- HiLoSel_E  input  1  0 selects LO, 1 selects HI for MFLO/MFHI.
- HiLo_E  output  WIDTH  combinational read of the selected HI/LO register.
- MDUUse_D  input  1  Decode instruction is an MDU op, MTHI/MTLO or MFHI/MFLO.
- MDUBusy  output  1  operation in progress.
- MDUStall_D  output  1  stall request to the hazard unit; equals MDUBusy AND MDUUse_D (combinational).
- Done  output  1  one-cycle pulse when HI/LO are written by an arithmetic op.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a clock edge):
  - state goes to IDLE; HI, LO, counter and internal accumulators are cleared to 0.
  - MDUBusy is 0, Done is 0, and HiLo_E therefore reads 0.
  - Reset asserted mid-operation aborts the operation. No HI/LO write occurs afterwards.
- States:
  - IDLE:
    - Start_E=1 accepts the op: latch magnitudes |A| and |B| (signed ops only; unsigned ops latch raw values), latch sign of quotient/product and sign of dividend, and load counter with WIDTH-1.
    - Next state is MUL for MDUOp_E[1]=0, DIV for MDUOp_E[1]=1.
    - Exception: DIV/DIVU with SrcB_E=0 goes directly to FIX with the divide-by-zero flag set.
  - MUL: one shift-add step per cycle over a 2*WIDTH accumulator. After the step with counter==0, go to FIX. Otherwise decrement the counter.
  - DIV: one restoring-division step per cycle, producing a quotient bit and a partial remainder. After the step with counter==0, go to FIX.
  - FIX: apply sign correction and write HI/LO at this edge. Done=1 during FIX. Next state is IDLE.
- Latency: acceptance edge E0, then WIDTH cycles in MUL/DIV, then 1 FIX cycle.
  - MDUBusy is high for exactly WIDTH+1 cycles (33 for WIDTH=32), starting the cycle after E0.
  - New HI/LO are visible on HiLo_E in the first cycle MDUBusy is low.
  - Divide-by-zero: MDUBusy is high for 1 cycle (FIX only).
- Results:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product. For MULT, negate the magnitude product when the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. For DIV, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
  - DIV of 0x80000000 by -1 gives LO=0x80000000, HI=0.
  - Divide by zero (signed or unsigned): LO = all ones, HI = SrcA_E raw.
- MTHI/MTLO:
  - Honoured only in IDLE with Start_E=0. SrcA_E is written to HI/LO at that edge.
  - WriteHi_E and WriteLo_E both high writes both registers.
- Illegal combinations, all ignored with no state change:
  - Start_E or WriteHi_E/WriteLo_E while MDUBusy=1. The hazard unit prevents these by stalling.
  - Start_E together with a write in IDLE: Start_E wins and the writes are dropped.
- HiLo_E always reflects committed HI/LO. It is never forwarded from an in-flight operation.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> MDUBusy high 33 cycles, Done pulses in the last busy cycle, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> MDUBusy high 1 cycle, LO=0xFFFFFFFF, HI=0x1234.
- During a MULT: MDUUse_D=1 -> MDUStall_D=1 every busy cycle and 0 once idle; Start_E=1 and WriteLo_E=1 pulsed mid-op -> ignored, final result unchanged.
- rst_n low for one edge at busy cycle 10 of a DIVU -> next cycle MDUBusy=0, HI=LO=0, no Done pulse.
- Afterwards MTLO 0xCAFEBABE with HiLoSel_E=0 -> HiLo_E=0xCAFEBABE the next cycle.
